pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Hazard/stall sequencer for the 5-stage MIPS pipeline, sitting beside the decoder in ID.
//  Drives PC and pipeline-register enables/bubbles for four cases: load-use hazards,
//  taken-branch flush, multi-cycle mul/div occupancy and data-memory wait states.
//  Also keeps a saturating stall-cycle performance counter.
// PARAMETERS
//  MD_CYCLES  4   mul/div latency in cycles (>=2)
//  CNT_W      16  width of stall-cycle counter
// PORTS
//  i_pctl_clk              in   1      clock
//  i_pctl_rst_n            in   1      async active-low reset
//  i_pctl_id_valid         in   1      ID stage holds a real instruction
//  i_pctl_id_rs            in   5      ID source reg rs
//  i_pctl_id_rt            in   5      ID source reg rt
//  i_pctl_ex_memread       in   1      EX instruction is a load
//  i_pctl_ex_rt            in   5      load destination reg in EX
//  i_pctl_ex_branch_taken  in   1      branch resolved taken in EX
//  i_pctl_ex_muldiv_start  in   1      EX issues mul/div (1-cycle pulse)
//  i_pctl_mem_req          in   1      MEM stage access in progress
//  i_pctl_mem_ready        in   1      data memory completes access this cycle
//  i_pctl_cnt_clr          in   1      sync clear of stall counter
//  o_pctl_pc_en            out  1      PC update enable
//  o_pctl_ifid_en          out  1      IF/ID load enable
//  o_pctl_ifid_flush       out  1      IF/ID load NOP
//  o_pctl_idex_en          out  1      ID/EX load enable
//  o_pctl_idex_bubble      out  1      ID/EX load NOP (control bits zero)
//  o_pctl_exmem_en         out  1      EX/MEM load enable
//  o_pctl_exmem_bubble     out  1      EX/MEM load NOP
//  o_pctl_memwb_bubble     out  1      MEM/WB load NOP
//  o_pctl_muldiv_done      out  1      mul/div result captured into EX/MEM this cycle
//  o_pctl_state            out  2      FSM state (RUN=00, MULDIV=01, MEMWAIT=10)
//  o_pctl_stall_cnt        out  CNT_W  cycles with o_pctl_pc_en=0
// BEHAVIOUR
//  Reset (rst_n low): state=RUN, md counter=0, stall_cnt=0.
//  - Outputs while in reset: all *_en=0, ifid_flush=idex_bubble=exmem_bubble=memwb_bubble=1, done=0.
//  Outputs are combinational from state, md counter and inputs.
//  - Priority (first match wins); signals not named take the default:
//    all *_en=1, all flush/bubble=0, done=0.
//  1 mem_stall = mem_req & ~mem_ready: pc/ifid/idex/exmem_en=0, memwb_bubble=1.
//  2 md_busy = (RUN & muldiv_start) | (MULDIV & cnt!=0): pc/ifid/idex_en=0, exmem_bubble=1.
//  3 MULDIV & cnt==0: default outputs, done=1.
//  4 branch_taken: ifid_flush=1, idex_bubble=1; pc_en stays 1 (PC loads target).
//    A load-use hit in the same cycle is suppressed.
//  5 load_use = ex_memread & ex_rt!=0 & id_valid & (ex_rt==id_rs | ex_rt==id_rt):
//    pc_en=0, ifid_en=0, idex_bubble=1 (single cycle; load moves to MEM).
//  FSM transitions:
//  - RUN -> MEMWAIT on mem_stall; muldiv_start is ignored while frozen (EX re-presents it).
//  - RUN -> MULDIV on muldiv_start & ~mem_stall; cnt <= MD_CYCLES-1.
//  - MULDIV: cnt decrements every cycle (saturates at 0), including under mem_stall.
//    MULDIV -> RUN when cnt==0 & ~mem_stall.
//    If cnt==0 while mem_stall, stay in MULDIV; done is deferred until the stall clears.
//  - MEMWAIT -> RUN when mem_ready=1 or mem_req=0 (aborted access).
//  - Illegal state 11 -> RUN.
//  Mul/div freeze: exactly MD_CYCLES frozen cycles (start cycle + MD_CYCLES-1), released
//  the following cycle with done=1.
//  stall_cnt: +1 on each post-reset cycle with pc_en=0; saturates at 2^CNT_W-1.
//  - cnt_clr has priority over increment (counter reads 0 the next cycle).
//  Reset mid-operation aborts mul/div and wait states immediately; no done pulse is issued.
// TESTING
//  1 Load-use: ex_memread=1, ex_rt=5, id_rs=5, id_valid=1 -> pc_en=0, ifid_en=0, idex_bubble=1
//    for one cycle. Repeat with ex_rt=0 -> no stall.
//  2 Branch plus load-use hit in the same cycle -> ifid_flush=1, idex_bubble=1, pc_en=1,
//    ifid_en=1, stall_cnt unchanged.
//  3 MD_CYCLES=4, muldiv_start at cycle t -> pc_en=0 at t..t+3, state=01 at t+1..t+4,
//    done=1 and pc_en=1 at t+4, state=00 at t+5, stall_cnt +4.
//  4 mem_req=1, mem_ready=0 for 3 cycles -> all four *_en=0, memwb_bubble=1,
//    state=10 from 2nd cycle. mem_ready=1 -> enables=1, state=00 next cycle.
//  5 Start mul/div, then hold mem_ready=0 across the cycle where cnt reaches 0 ->
//    done stays 0 and state stays 01 until mem_ready=1, then done=1 for one cycle.
//  6 CNT_W=4: stall 20 cycles -> stall_cnt=15 held. cnt_clr -> 0.
//    Assert rst_n=0 mid-MULDIV -> state=00, stall_cnt=0, no done pulse.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline: load-use, branch flush,
// mul/div occupancy and data-memory wait states, plus a saturating stall counter.
module pipeline_ctrl #(
  parameter int unsigned MD_CYCLES = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             i_pctl_clk,
  input  logic             i_pctl_rst_n,
  input  logic             i_pctl_id_valid,
  input  logic [4:0]       i_pctl_id_rs,
  input  logic [4:0]       i_pctl_id_rt,
  input  logic             i_pctl_ex_memread,
  input  logic [4:0]       i_pctl_ex_rt,
  input  logic             i_pctl_ex_branch_taken,
  input  logic             i_pctl_ex_muldiv_start,
  input  logic             i_pctl_mem_req,
  input  logic             i_pctl_mem_ready,
  input  logic             i_pctl_cnt_clr,
  output logic             o_pctl_pc_en,
  output logic             o_pctl_ifid_en,
  output logic             o_pctl_ifid_flush,
  output logic             o_pctl_idex_en,
  output logic             o_pctl_idex_bubble,
  output logic             o_pctl_exmem_en,
  output logic             o_pctl_exmem_bubble,
  output logic             o_pctl_memwb_bubble,
  output logic             o_pctl_muldiv_done,
  output logic [1:0]       o_pctl_state,
  output logic [CNT_W-1:0] o_pctl_stall_cnt
);

  localparam int unsigned MdW = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;
  localparam logic [MdW-1:0] MdLoad = MdW'(MD_CYCLES - 1);

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StMulDiv  = 2'b01,
    StMemWait = 2'b10,
    StIllegal = 2'b11
  } state_e;

  state_e           state_q;
  logic [MdW-1:0]   md_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic mem_stall;
  logic md_busy;
  logic md_done;
  logic load_use;

  assign mem_stall = i_pctl_mem_req & ~i_pctl_mem_ready;
  assign md_busy   = ((state_q == StRun) & i_pctl_ex_muldiv_start) |
                     ((state_q == StMulDiv) & (md_cnt_q != '0));
  assign md_done   = (state_q == StMulDiv) & (md_cnt_q == '0);
  assign load_use  = i_pctl_ex_memread & (i_pctl_ex_rt != 5'd0) & i_pctl_id_valid &
                     ((i_pctl_ex_rt == i_pctl_id_rs) | (i_pctl_ex_rt == i_pctl_id_rt));

  // Priority-ordered hazard resolution; the first matching case owns the outputs.
  always_comb begin
    o_pctl_pc_en        = 1'b1;
    o_pctl_ifid_en      = 1'b1;
    o_pctl_ifid_flush   = 1'b0;
    o_pctl_idex_en      = 1'b1;
    o_pctl_idex_bubble  = 1'b0;
    o_pctl_exmem_en     = 1'b1;
    o_pctl_exmem_bubble = 1'b0;
    o_pctl_memwb_bubble = 1'b0;
    o_pctl_muldiv_done  = 1'b0;
    if (!i_pctl_rst_n) begin
      o_pctl_pc_en        = 1'b0;
      o_pctl_ifid_en      = 1'b0;
      o_pctl_idex_en      = 1'b0;
      o_pctl_exmem_en     = 1'b0;
      o_pctl_ifid_flush   = 1'b1;
      o_pctl_idex_bubble  = 1'b1;
      o_pctl_exmem_bubble = 1'b1;
      o_pctl_memwb_bubble = 1'b1;
    end else if (mem_stall) begin
      o_pctl_pc_en        = 1'b0;
      o_pctl_ifid_en      = 1'b0;
      o_pctl_idex_en      = 1'b0;
      o_pctl_exmem_en     = 1'b0;
      o_pctl_memwb_bubble = 1'b1;
    end else if (md_busy) begin
      o_pctl_pc_en        = 1'b0;
      o_pctl_ifid_en      = 1'b0;
      o_pctl_idex_en      = 1'b0;
      o_pctl_exmem_bubble = 1'b1;
    end else if (md_done) begin
      o_pctl_muldiv_done  = 1'b1;
    end else if (i_pctl_ex_branch_taken) begin
      // PC loads the branch target; a concurrent load-use hit is moot.
      o_pctl_ifid_flush   = 1'b1;
      o_pctl_idex_bubble  = 1'b1;
    end else if (load_use) begin
      o_pctl_pc_en        = 1'b0;
      o_pctl_ifid_en      = 1'b0;
      o_pctl_idex_bubble  = 1'b1;
    end
  end

  always_ff @(posedge i_pctl_clk or negedge i_pctl_rst_n) begin
    if (!i_pctl_rst_n) begin
      state_q  <= StRun;
      md_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (mem_stall) begin
            state_q <= StMemWait;
          end else if (i_pctl_ex_muldiv_start) begin
            state_q  <= StMulDiv;
            md_cnt_q <= MdLoad;
          end
        end
        StMulDiv: begin
          // The unit keeps computing under a memory stall; only the release waits.
          if (md_cnt_q != '0) begin
            md_cnt_q <= md_cnt_q - 1'b1;
          end else if (!mem_stall) begin
            state_q <= StRun;
          end
        end
        StMemWait: begin
          if (i_pctl_mem_ready || !i_pctl_mem_req) begin
            state_q <= StRun;
          end
        end
        default: begin
          state_q  <= StRun;
          md_cnt_q <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_pctl_clk or negedge i_pctl_rst_n) begin
    if (!i_pctl_rst_n) begin
      stall_cnt_q <= '0;
    end else if (i_pctl_cnt_clr) begin
      stall_cnt_q <= '0;
    end else if (!o_pctl_pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign o_pctl_state     = state_q;
  assign o_pctl_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (MD_CYCLES=4, CNT_W=4): each cycle drives
// inputs after the clock edge and checks the combinational outputs mid-cycle.
module tb_pipeline_ctrl;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       ex_memread;
  logic [4:0] ex_rt;
  logic       ex_branch_taken;
  logic       ex_muldiv_start;
  logic       mem_req;
  logic       mem_ready;
  logic       cnt_clr;
  logic       pc_en;
  logic       ifid_en;
  logic       ifid_flush;
  logic       idex_en;
  logic       idex_bubble;
  logic       exmem_en;
  logic       exmem_bubble;
  logic       memwb_bubble;
  logic       muldiv_done;
  logic [1:0] state;
  logic [3:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  pipeline_ctrl #(
    .MD_CYCLES (4),
    .CNT_W     (4)
  ) dut (
    .i_pctl_clk             (clk),
    .i_pctl_rst_n           (rst_n),
    .i_pctl_id_valid        (id_valid),
    .i_pctl_id_rs           (id_rs),
    .i_pctl_id_rt           (id_rt),
    .i_pctl_ex_memread      (ex_memread),
    .i_pctl_ex_rt           (ex_rt),
    .i_pctl_ex_branch_taken (ex_branch_taken),
    .i_pctl_ex_muldiv_start (ex_muldiv_start),
    .i_pctl_mem_req         (mem_req),
    .i_pctl_mem_ready       (mem_ready),
    .i_pctl_cnt_clr         (cnt_clr),
    .o_pctl_pc_en           (pc_en),
    .o_pctl_ifid_en         (ifid_en),
    .o_pctl_ifid_flush      (ifid_flush),
    .o_pctl_idex_en         (idex_en),
    .o_pctl_idex_bubble     (idex_bubble),
    .o_pctl_exmem_en        (exmem_en),
    .o_pctl_exmem_bubble    (exmem_bubble),
    .o_pctl_memwb_bubble    (memwb_bubble),
    .o_pctl_muldiv_done     (muldiv_done),
    .o_pctl_state           (state),
    .o_pctl_stall_cnt       (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    id_valid        = 1'b0;
    id_rs           = 5'd0;
    id_rt           = 5'd0;
    ex_memread      = 1'b0;
    ex_rt           = 5'd0;
    ex_branch_taken = 1'b0;
    ex_muldiv_start = 1'b0;
    mem_req         = 1'b0;
    mem_ready       = 1'b0;
    cnt_clr         = 1'b0;
  endtask

  // Advance to just after the next rising edge and return inputs to idle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    set_idle();
  endtask

  // Checks all four enables against one expected value.
  task automatic check_ens(input string tag, input logic exp);
    check({tag, "_pc_en"}, pc_en, exp);
    check({tag, "_ifid_en"}, ifid_en, exp);
    check({tag, "_idex_en"}, idex_en, exp);
    check({tag, "_exmem_en"}, exmem_en, exp);
  endtask

  initial begin
    set_idle();
    rst_n = 1'b0;
    #3;
    // In reset
    check_ens("rst", 1'b0);
    check("rst_ifid_flush", ifid_flush, 1);
    check("rst_idex_bubble", idex_bubble, 1);
    check("rst_exmem_bubble", exmem_bubble, 1);
    check("rst_memwb_bubble", memwb_bubble, 1);
    check("rst_done", muldiv_done, 0);
    check("rst_state", state, 0);
    check("rst_cnt", stall_cnt, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    next_cycle();
    #1;
    check_ens("idle", 1'b1);
    check("idle_bubble", idex_bubble, 0);
    check("idle_cnt", stall_cnt, 0);

    // Load-use via rs
    next_cycle();
    ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_valid = 1'b1;
    #1;
    check("lu_pc_en", pc_en, 0);
    check("lu_ifid_en", ifid_en, 0);
    check("lu_idex_bubble", idex_bubble, 1);
    check("lu_idex_en", idex_en, 1);
    check("lu_exmem_en", exmem_en, 1);
    next_cycle();
    #1;
    check("lu_after_pc_en", pc_en, 1);
    check("lu_after_cnt", stall_cnt, 1);
    // ex_rt = 0 never hazards
    next_cycle();
    ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_valid = 1'b1;
    #1;
    check("lu_r0_pc_en", pc_en, 1);
    check("lu_r0_bubble", idex_bubble, 0);
    // Load-use via rt
    next_cycle();
    ex_memread = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_valid = 1'b1;
    #1;
    check("lu_rt_pc_en", pc_en, 0);
    // No real instruction in ID
    next_cycle();
    ex_memread = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_valid = 1'b0;
    #1;
    check("lu_novalid_pc_en", pc_en, 1);
    check("lu_cnt2", stall_cnt, 2);

    // Branch taken with a simultaneous load-use hit
    next_cycle();
    ex_branch_taken = 1'b1;
    ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_valid = 1'b1;
    #1;
    check("br_ifid_flush", ifid_flush, 1);
    check("br_idex_bubble", idex_bubble, 1);
    check("br_pc_en", pc_en, 1);
    check("br_ifid_en", ifid_en, 1);
    next_cycle();
    cnt_clr = 1'b1;
    #1;
    check("br_cnt", stall_cnt, 2);

    // Mul/div occupancy, start at t
    next_cycle();
    ex_muldiv_start = 1'b1;
    #1;
    check("md_t_cnt", stall_cnt, 0);
    check("md_t_pc_en", pc_en, 0);
    check("md_t_exmem_bubble", exmem_bubble, 1);
    check("md_t_exmem_en", exmem_en, 1);
    check("md_t_state", state, 0);
    for (int i = 1; i <= 3; i++) begin
      next_cycle();
      #1;
      check($sformatf("md_t%0d_pc_en", i), pc_en, 0);
      check($sformatf("md_t%0d_state", i), state, 1);
      check($sformatf("md_t%0d_done", i), muldiv_done, 0);
    end
    next_cycle();
    #1;
    check("md_t4_pc_en", pc_en, 1);
    check("md_t4_done", muldiv_done, 1);
    check("md_t4_state", state, 1);
    check("md_t4_bubble", exmem_bubble, 0);
    next_cycle();
    #1;
    check("md_t5_state", state, 0);
    check("md_t5_done", muldiv_done, 0);
    check("md_t5_cnt", stall_cnt, 4);

    // Memory wait states
    for (int i = 1; i <= 3; i++) begin
      if (i > 1) next_cycle();
      mem_req = 1'b1; mem_ready = 1'b0;
      #1;
      check_ens($sformatf("mw%0d", i), 1'b0);
      check($sformatf("mw%0d_memwb", i), memwb_bubble, 1);
      check($sformatf("mw%0d_state", i), state, (i == 1) ? 0 : 2);
      if (i < 3) #1;
    end
    next_cycle();
    mem_req = 1'b1; mem_ready = 1'b1;
    #1;
    check_ens("mw_rdy", 1'b1);
    check("mw_rdy_memwb", memwb_bubble, 0);
    check("mw_rdy_state", state, 2);
    next_cycle();
    #1;
    check("mw_end_state", state, 0);
    check("mw_end_cnt", stall_cnt, 7);

    // Mul/div completion deferred by a memory stall
    next_cycle();
    ex_muldiv_start = 1'b1;
    for (int i = 1; i <= 3; i++) next_cycle();
    for (int i = 4; i <= 5; i++) begin
      next_cycle();
      mem_req = 1'b1; mem_ready = 1'b0;
      #1;
      check($sformatf("mdw_t%0d_done", i), muldiv_done, 0);
      check($sformatf("mdw_t%0d_state", i), state, 1);
      check($sformatf("mdw_t%0d_pc_en", i), pc_en, 0);
    end
    next_cycle();
    mem_req = 1'b1; mem_ready = 1'b1;
    #1;
    check("mdw_rel_done", muldiv_done, 1);
    check("mdw_rel_pc_en", pc_en, 1);
    check("mdw_rel_state", state, 1);
    next_cycle();
    #1;
    check("mdw_end_done", muldiv_done, 0);
    check("mdw_end_state", state, 0);
    check("mdw_end_cnt", stall_cnt, 13);

    // Counter saturation over 20 stall cycles
    next_cycle();
    cnt_clr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      mem_req = 1'b1; mem_ready = 1'b0;
      if (i == 0) begin
        #1;
        check("sat_start_cnt", stall_cnt, 0);
      end
    end
    next_cycle();
    mem_req = 1'b1; mem_ready = 1'b0;
    #1;
    check("sat_cnt", stall_cnt, 15);
    cnt_clr = 1'b1;  // clear wins over the increment of this stalled cycle
    next_cycle();
    mem_req = 1'b1; mem_ready = 1'b1;
    #1;
    check("clr_cnt", stall_cnt, 0);
    next_cycle();
    #1;
    check("clr_hold_cnt", stall_cnt, 0);
    check("clr_state", state, 0);

    // Reset mid-MULDIV
    next_cycle();
    ex_muldiv_start = 1'b1;
    next_cycle();
    #1;
    check("rmd_state", state, 1);
    next_cycle();
    #1;
    check("rmd_pre_cnt", stall_cnt, 2);
    rst_n = 1'b0;
    #1;
    check("rmd_state0", state, 0);
    check("rmd_cnt0", stall_cnt, 0);
    check("rmd_done0", muldiv_done, 0);
    check("rmd_pc_en0", pc_en, 0);
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      #1;
      check($sformatf("rmd_post%0d_done", i), muldiv_done, 0);
      check($sformatf("rmd_post%0d_state", i), state, 0);
      check($sformatf("rmd_post%0d_pc_en", i), pc_en, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
